shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_pkg.sv | 13 +
 rtl/shift_bit_counter.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 98 +++++++++
 tb/tb_shift_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and default constants for the shift sequencer.
package shift_seq_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam bit DEF_MSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit counter for one serial word. Counts enabled edges from zero.
// tc flags the edge that completes the word: the count is WIDTH-1 and
// the enable is active.
module shift_bit_counter
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic clk,
   input  logic clear,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] count;

   // clear wins over enable; the owner stops enabling once WIDTH is reached
   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (en)
         count <= count + CW'(1);
   end

   assign tc = en && (count == LAST);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serialiser/deserialiser sequencer. It loads a parallel word, shifts it
// out one bit per tick, and shifts ser_in in from the opposite end. The
// assembled word is then held on cap_data until the consumer accepts it.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             tick,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_in,
   output logic             cap_valid,
   output logic [WIDTH-1:0] cap_data,
   input  logic             cap_ready,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg, shreg_shifted;
   logic             load_fire, shift_en, cnt_tc;

   assign load_fire = (state_q == IDLE) && load_valid;
   assign shift_en  = (state_q == SHIFT) && tick;

   // Shift toward the output end and feed ser_in in at the other end.
   // A 1-bit word has no interior bits, so it is simply replaced.
   generate
      if (WIDTH == 1) begin : gen_w1
         assign shreg_shifted = ser_in;
      end else if (MSB_FIRST) begin : gen_msb
         assign shreg_shifted = {shreg[WIDTH-2:0], ser_in};
      end else begin : gen_lsb
         assign shreg_shifted = {ser_in, shreg[WIDTH-1:1]};
      end
   endgenerate

   // The output bit comes straight off the register end, so it is glitch-free.
   assign ser_out  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
   assign cap_data = cap_valid ? shreg : '0;

   shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .clear (reset | load_fire),
      .en    (shift_en),
      .tc    (cnt_tc)
   );

   // State register; reset aborts any transfer in flight
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Shift register: parallel load in IDLE, shift on tick in SHIFT
   always_ff @(posedge clk) begin
      if (reset)
         shreg <= '0;
      else if (load_fire)
         shreg <= load_data;
      else if (shift_en)
         shreg <= shreg_shifted;
   end

   // Next state and handshake outputs
   always_comb begin
      state_d    = state_q;
      load_ready = 1'b0;
      ser_valid  = 1'b0;
      cap_valid  = 1'b0;
      busy       = 1'b1;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
            busy       = 1'b0;
            if (load_valid) state_d = SHIFT;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            if (cnt_tc) state_d = DONE;
         end
         DONE: begin
            cap_valid = 1'b1;
            if (cap_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl. Three instances share one stimulus stream:
// WIDTH=8 MSB-first, WIDTH=8 LSB-first and WIDTH=1. A word-level model
// predicts each instance from the loaded word and the bits fed in.
module tb_shift_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, load_valid, tick, cap_ready, lb, sin_val;
   logic [7:0] load_data;

   logic       lr0, so0, sv0, cv0, bz0, si0;
   logic       lr1, so1, sv1, cv1, bz1, si1;
   logic       lr2, so2, sv2, cv2, bz2, si2;
   logic [7:0] cd0, cd1;
   logic [0:0] cd2;

   assign si0 = lb ? so0 : sin_val;
   assign si1 = lb ? so1 : sin_val;
   assign si2 = lb ? so2 : sin_val;

   shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
      .load_ready(lr0), .tick(tick), .ser_out(so0), .ser_valid(sv0), .ser_in(si0),
      .cap_valid(cv0), .cap_data(cd0), .cap_ready(cap_ready), .busy(bz0));

   shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
      .load_ready(lr1), .tick(tick), .ser_out(so1), .ser_valid(sv1), .ser_in(si1),
      .cap_valid(cv1), .cap_data(cd1), .cap_ready(cap_ready), .busy(bz1));

   shift_seq_ctrl #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_1 (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data[0:0]),
      .load_ready(lr2), .tick(tick), .ser_out(so2), .ser_valid(sv2), .ser_in(si2),
      .cap_valid(cv2), .cap_data(cd2), .cap_ready(cap_ready), .busy(bz2));

   logic       a_lr[3], a_so[3], a_sv[3], a_cv[3], a_bz[3];
   logic [7:0] a_cd[3];
   assign a_lr[0] = lr0; assign a_lr[1] = lr1; assign a_lr[2] = lr2;
   assign a_so[0] = so0; assign a_so[1] = so1; assign a_so[2] = so2;
   assign a_sv[0] = sv0; assign a_sv[1] = sv1; assign a_sv[2] = sv2;
   assign a_cv[0] = cv0; assign a_cv[1] = cv1; assign a_cv[2] = cv2;
   assign a_bz[0] = bz0; assign a_bz[1] = bz1; assign a_bz[2] = bz2;
   assign a_cd[0] = cd0; assign a_cd[1] = cd1; assign a_cd[2] = {7'b0, cd2};

   int n_tests = 0;
   int n_fail  = 0;

   // model: 0 = waiting for a word, 1 = k bits of word moved, 2 = holding cap
   int         m_st[3];
   int         m_k[3];
   logic [7:0] m_word[3];
   logic [7:0] m_cap[3];

   function automatic int wid(input int d);
      return (d == 2) ? 1 : 8;
   endfunction

   function automatic bit msb(input int d);
      return d != 1;
   endfunction

   // the k-th outgoing bit is always a bit of the original word
   function automatic logic exp_so(input int d);
      if (m_st[d] != 1) return 1'b0;
      return msb(d) ? m_word[d][wid(d)-1-m_k[d]] : m_word[d][m_k[d]];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d_flags", d),
               {28'd0, a_bz[d], a_lr[d], a_sv[d], a_cv[d]},
               {28'd0, m_st[d] != 0, m_st[d] == 0, m_st[d] == 1, m_st[d] == 2});
         check($sformatf("d%0d_cap_data", d), a_cd[d], (m_st[d] == 2) ? m_cap[d] : 8'h00);
         if (m_st[d] == 1)
            check($sformatf("d%0d_ser_out", d), a_so[d], exp_so(d));
      end
   endtask

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         if (reset) begin
            m_st[d] = 0;
            m_k[d]  = 0;
         end else begin
            case (m_st[d])
               0: if (load_valid) begin
                  m_word[d] = load_data & ((wid(d) == 8) ? 8'hFF : 8'h01);
                  m_cap[d]  = 8'h00;
                  m_k[d]    = 0;
                  m_st[d]   = 1;
               end
               1: if (tick) begin
                  logic b;
                  b = lb ? exp_so(d) : sin_val;
                  if (msb(d)) m_cap[d][wid(d)-1-m_k[d]] = b;
                  else        m_cap[d][m_k[d]] = b;
                  m_k[d]++;
                  if (m_k[d] == wid(d)) m_st[d] = 2;
               end
               default: if (cap_ready) m_st[d] = 0;
            endcase
         end
      end
   endtask

   task automatic cycle();
      check_all();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      load_valid = 1'b0; tick = 1'b1; cap_ready = 1'b1;
      for (int i = 0; i < 40 && (m_st[0] != 0 || m_st[1] != 0 || m_st[2] != 0); i++)
         cycle();
      check("drain_idle", {m_st[0] != 0, m_st[1] != 0, m_st[2] != 0}, 3'b000);
      cap_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      bit         lb;
      bit         sin;
      int         per;
      bit         hold_lv;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
   } vec_t;

   task automatic run_word(input vec_t v);
      bit seen;
      int lat;
      drain();
      load_valid = 1'b1; load_data = v.data; lb = v.lb; sin_val = v.sin;
      tick = 1'b1; cap_ready = 1'b0;
      cycle();                                  // edge T: word accepted
      if (!v.hold_lv) load_valid = 1'b0;
      load_data = ~v.data;
      seen = 1'b0; lat = 0;
      for (int j = 1; j <= 8 * v.per + 2 && !seen; j++) begin
         tick = (j % v.per) == 0;
         cycle();
         if (cv0 && !seen) begin seen = 1'b1; lat = j; end
      end
      check("latency", lat, 8 * v.per);
      tick = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("cap_hold_m", cd0, v.exp_m);
      end
      check("cap_m", cd0, v.exp_m);
      check("cap_l", cd1, v.exp_l);
      check("lr_in_done", lr0, 1'b0);
      cap_ready = 1'b1;
      cycle();
      cap_ready = 1'b0;
      check("idle_after_ack", {bz0, lr0}, 2'b01);
      if (v.hold_lv) begin
         cycle();
         check("reload_after_idle", {bz0, lr0}, 2'b10);
      end
      load_valid = 1'b0;
   endtask

   vec_t vt[5];

   initial begin
      vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b0, 8'hA5, 8'hA5};
      vt[1] = '{8'h01, 1'b0, 1'b0, 1, 1'b0, 8'h00, 8'h00};
      vt[2] = '{8'h3C, 1'b1, 1'b0, 3, 1'b0, 8'h3C, 8'h3C};
      vt[3] = '{8'h5A, 1'b0, 1'b1, 1, 1'b1, 8'hFF, 8'hFF};
      vt[4] = '{8'hC3, 1'b0, 1'b0, 2, 1'b0, 8'h00, 8'h00};

      for (int d = 0; d < 3; d++) begin
         m_st[d] = 0; m_k[d] = 0; m_word[d] = 8'h00; m_cap[d] = 8'h00;
      end
      reset = 1'b1; load_valid = 1'b1; load_data = 8'hFF; tick = 1'b1;
      cap_ready = 1'b0; lb = 1'b0; sin_val = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("reset_d%0d", d),
               {a_bz[d], a_sv[d], a_so[d], a_cv[d], a_lr[d], a_cd[d]},
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
      reset = 1'b0; load_valid = 1'b0;

      foreach (vt[i]) run_word(vt[i]);

      // abort mid-word: partial data must never surface
      drain();
      load_valid = 1'b1; load_data = 8'h96; lb = 1'b1; tick = 1'b0;
      cycle();
      load_valid = 1'b0; tick = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("abort_state", {bz0, cv0, lr0, so0, cd0}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      run_word('{8'hFF, 1'b1, 1'b0, 1, 1'b0, 8'hFF, 8'hFF});

      // one-bit word completes on a single tick
      drain();
      reset = 1'b1; cycle(); reset = 1'b0;
      load_valid = 1'b1; load_data = 8'h01; lb = 1'b0; sin_val = 1'b0; tick = 1'b0;
      cycle();
      load_valid = 1'b0;
      check("w1_shift", {bz2, sv2, so2}, 3'b111);
      tick = 1'b1;
      cycle();
      check("w1_done", {cv2, cd2}, 2'b10);
      drain();

      // random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         load_valid = $urandom_range(0, 1);
         load_data  = 8'($urandom);
         tick       = ($urandom_range(0, 3) != 0);
         cap_ready  = ($urandom_range(0, 2) == 0);
         lb         = $urandom_range(0, 1);
         sin_val    = $urandom_range(0, 1);
         cycle();
      end
      reset = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
